memory_unit_param: RTL and testbench
====================================

// Module: memory_unit_param
// PURPOSE
// - Parametrised single-port data memory for the processor datapath: configurable word width, depth and read latency.
// - Adds per-byte write enables, a ready/valid handshake and a hardware clear sweep that runs after reset or on request.
// - Sits between the load/store stage and the register file.
// PARAMETERS
// - DATA_W          32   word width in bits; must be a multiple of 8
// - ADDR_W          8    address width; DEPTH = 2**ADDR_W words
// - READ_LAT        1    read latency in cycles; legal values are 1 or 2
// - CLEAR_ON_RESET  1    1: run the clear sweep after reset; 0: memory is ready immediately after reset, contents undefined
// PORTS
// - clk       in   1         clock; all state updates on its rising edge
// - rst       in   1         reset, asynchronous, active-high
// - en        in   1         chip enable / access request
// - wen       in   1         write enable; 1 = write, 0 = read; sampled only with en
// - be        in   DATA_W/8  byte write enables; be[i] covers data_in[8i+7:8i]
// - addr      in   ADDR_W    word address
// - data_in   in   DATA_W    write data
// - clr       in   1         pulse: start a clear sweep
// - ready     out  1         memory accepts an access this cycle
// - data_out  out  DATA_W    read data
// - valid     out  1         data_out holds read data this cycle
// BEHAVIOUR
// - Reset values: data_out=0, valid=0, sweep counter=0, read pipeline empty.
//   - ready=0 during reset; after reset, ready=0 if CLEAR_ON_RESET=1, else ready=1.
// - FSM states:
//   - CLEAR: write 0 to word[cnt]; cnt++; at cnt==DEPTH-1 write the last word, then go to IDLE. Takes exactly DEPTH cycles; ready=0 throughout.
//   - IDLE: ready=1; in this state only, en&&ready accepts an access.
// - Write (en=1, wen=1): word[addr] bytes with be[i]=1 are replaced by data_in; all other bytes are kept.
//   - Visible to a read issued the next cycle.
//   - No valid pulse; data_out unchanged.
// - Read (en=1, wen=0): data_out=word[addr] and valid=1 exactly READ_LAT cycles after acceptance. be is ignored.
//   - Back-to-back reads are accepted every cycle; results return in order.
// - en=0 in IDLE: after READ_LAT cycles data_out=0 and valid=0.
//   - Reads already accepted still complete normally.
// - clr in IDLE: go to CLEAR on the next edge, with cnt=0; ready drops that cycle.
//   - Any access presented in the same cycle as clr is dropped; clr wins.
//   - Reads accepted before clr still deliver their data.
// - clr in CLEAR: ignored; the sweep does not restart.
// - rst at any point, including mid-sweep or with a read in flight:
//   - The pipeline flushes immediately and outputs take their reset values.
//   - The sweep restarts from 0 after rst is released, if CLEAR_ON_RESET=1.
// - Address wrap: addr is exactly ADDR_W bits, so there is no out-of-range access. The sweep counter stops at DEPTH-1 and does not wrap.
// - be=0 with wen=1: legal no-op write.
// STRUCTURE
// - Package mem_pkg:
//   - typedef enum {CLEAR, IDLE} mem_state_t
//   - function bytes_of(DATA_W)
//   - constant MAX_READ_LAT=2
// - Sub-module mem_clear_ctrl (parametrised by ADDR_W, CLEAR_ON_RESET) owns:
//   - the FSM and sweep counter
//   - the outputs ready, clr_we, clr_addr
// - Top level owns the storage array, the byte-merge write and the READ_LAT-deep data/valid shift pipeline.
// TESTING
// - Reset then release, DATA_W=32, ADDR_W=8: ready=0 for 256 cycles, then 1. A read of addr 0xFF returns 0 with valid=1 one cycle later.
// - Write 0xDEADBEEF to 0x10 with be=4'b1111, then with data_in=0x000000AA and be=4'b0001: read 0x10 -> data_out=0xDEADBEAA.
// - Reads of addr 1,2,3 on consecutive cycles, READ_LAT=2: valid high on cycles 2,3,4 after the first read; data in order.
// - After a read, drop en: data_out=0 and valid=0 READ_LAT cycles later.
// - Write 0x12345678 to 0x05; pulse clr together with a read of 0x05: read dropped; ready=0 for 256 cycles; then read 0x05 -> 0.
// - Assert rst mid-sweep at cnt=100 and mid-read: valid=0 and data_out=0 immediately; after release the sweep takes the full 256 cycles again.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised data memory.
package mem_pkg;

    localparam int MAX_READ_LAT = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_t;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Clear-sweep controller: walks every word address writing zero, then opens the
// memory for accesses. A clr pulse in IDLE restarts the sweep; clr in CLEAR is ignored.
//
// state | meaning
// CLEAR | writing 0 to word[cnt], ready=0; leaves after the last word
// IDLE  | ready=1 unless clr or rst is asserted; accesses may be accepted
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam mem_state_t        RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ready is gated by clr so an access coinciding with clr is never accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = ~rst;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                ready = ~clr & ~rst;
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/memory_unit_param.sv
// Single-port data memory with byte enables, fixed read latency and a
// hardware clear sweep; sits between load/store and the register file.
module memory_unit_param
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int READ_LAT       = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        wen,
    input  logic [bytes_of(DATA_W)-1:0] be,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        clr,
    output logic                        ready,
    output logic [DATA_W-1:0]           data_out,
    output logic                        valid
);

    localparam int NB    = bytes_of(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT || (DATA_W % 8) != 0) begin : g_bad_param
        $error("memory_unit_param: unsupported READ_LAT or DATA_W");
    end

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc_wr, acc_rd;
    logic [DATA_W-1:0] wr_word;

    logic [DATA_W-1:0]   mem_q      [DEPTH];
    logic [DATA_W-1:0]   rd_data_q  [READ_LAT];
    logic [READ_LAT-1:0] rd_valid_q;

    mem_clear_ctrl #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign acc_wr = en & ready & wen;
    assign acc_rd = en & ready & ~wen;

    always_comb begin
        wr_word = mem_q[addr];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Storage has no reset; the clear sweep is what defines its contents.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (acc_wr) begin
            mem_q[addr] <= wr_word;
        end
    end

    // Idle slots carry zero so data_out returns to 0 once the pipe drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                rd_data_q[i] <= '0;
            end
            rd_valid_q <= '0;
        end else begin
            rd_data_q[0]  <= acc_rd ? mem_q[addr] : '0;
            rd_valid_q[0] <= acc_rd;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_data_q[i]  <= rd_data_q[i-1];
                rd_valid_q[i] <= rd_valid_q[i-1];
            end
        end
    end

    assign data_out = rd_data_q[READ_LAT-1];
    assign valid    = rd_valid_q[READ_LAT-1];

endmodule

// File: tb/tb_memory_unit_param.sv
// Directed bench: a READ_LAT=1 and a READ_LAT=2 instance share one stimulus stream.
module tb_memory_unit_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wen;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] data_in;
    logic        clr;

    logic        ready1, valid1, ready2, valid2;
    logic [31:0] dout1, dout2;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    memory_unit_param #(.DATA_W(32), .ADDR_W(8), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .be(be), .addr(addr),
        .data_in(data_in), .clr(clr), .ready(ready1), .data_out(dout1), .valid(valid1)
    );

    memory_unit_param #(.DATA_W(32), .ADDR_W(8), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .be(be), .addr(addr),
        .data_in(data_in), .clr(clr), .ready(ready2), .data_out(dout2), .valid(valid2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        en = 1'b0; wen = 1'b0; be = 4'h0; addr = 8'h00; data_in = 32'h0; clr = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        en = 1'b1; wen = 1'b1; addr = a; data_in = d; be = b;
        tick();
    endtask

    task automatic rd(input logic [7:0] a);
        en = 1'b1; wen = 1'b0; addr = a; be = 4'hF;
        tick();
    endtask

    // Counts cycles with ready low, bounded so a stuck sweep still reaches the summary.
    task automatic count_sweep(output int cycles, input int clr_at);
        cycles = 0;
        while (!ready1 && cycles < 1000) begin
            clr = (cycles == clr_at);
            tick();
            cycles++;
        end
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        #2;
        chk("rst_ready1", ready1, 0);
        chk("rst_ready2", ready2, 0);
        chk("rst_valid1", valid1, 0);
        chk("rst_dout1", dout1, 0);
        tick();
        tick();
        rst = 1'b0;

        count_sweep(n, -1);
        chk("init_sweep_len", n, 256);
        chk("init_ready2", ready2, 1);

        rd(8'hFF);
        idle_in();
        chk("rdFF_valid1", valid1, 1);
        chk("rdFF_dout1", dout1, 0);
        chk("rdFF_valid2_early", valid2, 0);
        tick();
        chk("rdFF_valid2", valid2, 1);
        chk("rdFF_dout2", dout2, 0);
        chk("rdFF_valid1_drop", valid1, 0);

        wr(8'h10, 32'hDEADBEEF, 4'b1111);
        chk("wr_no_valid", valid1, 0);
        wr(8'h10, 32'h000000AA, 4'b0001);
        rd(8'h10);
        idle_in();
        chk("merge_valid1", valid1, 1);
        chk("merge_dout1", dout1, 32'hDEADBEAA);
        tick();
        chk("merge_dout2", dout2, 32'hDEADBEAA);
        chk("merge_idle_dout1", dout1, 0);
        chk("merge_idle_valid1", valid1, 0);

        wr(8'h01, 32'h11111111, 4'hF);
        wr(8'h02, 32'h22222222, 4'hF);
        wr(8'h03, 32'h33333333, 4'hF);
        wr(8'h01, 32'hFFFFFFFF, 4'h0);
        rd(8'h01);
        chk("b2b_c1_dout1", dout1, 32'h11111111);
        chk("b2b_c1_valid2", valid2, 0);
        rd(8'h02);
        chk("b2b_c2_dout1", dout1, 32'h22222222);
        chk("b2b_c2_dout2", dout2, 32'h11111111);
        chk("b2b_c2_valid2", valid2, 1);
        rd(8'h03);
        chk("b2b_c3_dout1", dout1, 32'h33333333);
        chk("b2b_c3_dout2", dout2, 32'h22222222);
        idle_in();
        tick();
        chk("b2b_c4_valid1", valid1, 0);
        chk("b2b_c4_dout2", dout2, 32'h33333333);
        chk("b2b_c4_valid2", valid2, 1);
        tick();
        chk("b2b_c5_valid2", valid2, 0);
        chk("b2b_c5_dout2", dout2, 0);

        wr(8'h05, 32'h12345678, 4'hF);
        rd(8'h05);
        chk("pre_clr_dout1", dout1, 32'h12345678);
        en = 1'b1; wen = 1'b0; addr = 8'h05; clr = 1'b1;
        #1;
        chk("clr_ready_drop", ready1, 0);
        tick();
        idle_in();
        chk("clr_rd_dropped", valid1, 0);
        chk("clr_inflight_valid2", valid2, 1);
        chk("clr_inflight_dout2", dout2, 32'h12345678);
        count_sweep(n, 10);
        chk("clr_sweep_len", n, 256);
        rd(8'h05);
        chk("clr_rd05_valid", valid1, 1);
        chk("clr_rd05_dout", dout1, 0);
        rd(8'h10);
        idle_in();
        chk("clr_rd10_dout", dout1, 0);

        wr(8'h20, 32'hCAFEF00D, 4'hF);
        rd(8'h20);
        idle_in();
        chk("rstrd_dout1", dout1, 32'hCAFEF00D);
        rst = 1'b1;
        #1;
        chk("rstrd_valid1", valid1, 0);
        chk("rstrd_dout1_zero", dout1, 0);
        chk("rstrd_ready", ready1, 0);
        tick();
        chk("rstrd_valid2", valid2, 0);
        rst = 1'b0;

        repeat (100) tick();
        rst = 1'b1;
        #1;
        chk("midsweep_ready", ready1, 0);
        chk("midsweep_valid", valid1, 0);
        tick();
        rst = 1'b0;
        count_sweep(n, -1);
        chk("midsweep_len", n, 256);
        rd(8'h20);
        idle_in();
        chk("post_sweep_dout", dout1, 0);
        chk("post_sweep_valid", valid1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

endmodule
